// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt core arbiter and its round-robin picker.
package sqrt_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam int SQRT_WIDTH    = 16;
    localparam int DONE_HOLD_CYC = 10;

    typedef enum logic [2:0] {
        ARB_IDLE  = ST_IDLE,
        ARB_ISSUE = ST_ISSUE,
        ARB_WAIT  = ST_WAIT,
        ARB_RESP  = ST_RESP,
        ARB_DRAIN = ST_DRAIN
    } arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand_s;

    // Scan N positions starting at ptr and keep the first hit.
    always_comb begin
        grant  = {N{1'b0}};
        idx    = {IDX_W{1'b0}};
        valid  = 1'b0;
        cand_s = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!valid && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = IDX_W'(cand_s);
                valid         = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt core among N_REQ requesters.
// Optional WAIT timeout/abort enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter
    import sqrt_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = SQRT_WIDTH
`ifdef SQRT_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_flat,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH/2-1:0]       res,
    output logic                     err,
    output logic                     busy,
    output logic                     core_init,
    output logic [WIDTH-1:0]         core_op,
    output logic                     core_rst,
    input  logic                     core_done,
    input  logic [WIDTH/2-1:0]       core_res
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int RW    = WIDTH / 2;

    arb_state_t       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] owner_r;
    logic [N_REQ-1:0] owner_oh_r;
    logic [N_REQ-1:0] pick_grant_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_valid_s;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] timer_r;
    logic             aborted_r;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ARB_IDLE;
            ptr_r      <= {IDX_W{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            owner_oh_r <= {N_REQ{1'b0}};
            ack        <= {N_REQ{1'b0}};
            res        <= {RW{1'b0}};
            err        <= 1'b0;
            busy       <= 1'b0;
            core_init  <= 1'b0;
            core_op    <= {WIDTH{1'b0}};
            core_rst   <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
            timer_r    <= {TMR_W{1'b0}};
            aborted_r  <= 1'b0;
`endif
        end else begin
            ack       <= {N_REQ{1'b0}};
            core_init <= 1'b0;
            core_rst  <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        owner_r    <= pick_idx_s;
                        owner_oh_r <= pick_grant_s;
                        core_op    <= op_flat[pick_idx_s*WIDTH +: WIDTH];
                        core_init  <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ARB_ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARB_ISSUE: begin
`ifdef SQRT_ARB_TIMEOUT_EN
                    timer_r   <= {TMR_W{1'b0}};
                    aborted_r <= 1'b0;
`endif
                    state_r <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (core_done) begin
                        res     <= core_res;
                        state_r <= ARB_RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
                    end else if (timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
                        // TIMEOUT_CYC-th WAIT cycle without done: abort the core.
                        core_rst  <= 1'b1;
                        res       <= {RW{1'b0}};
                        err       <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= ARB_RESP;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
`else
                    end else begin
                        state_r <= ARB_WAIT;
                    end
`endif
                end
                ARB_RESP: begin
                    if (req[owner_r]) begin
                        ack <= owner_oh_r;
`ifdef SQRT_ARB_TIMEOUT_EN
                        err <= aborted_r;
`endif
                    end else begin
                        ack <= {N_REQ{1'b0}};
                    end
                    ptr_r <= IDX_W'(wrap_inc(32'(owner_r), 32'(N_REQ)));
`ifdef SQRT_ARB_TIMEOUT_EN
                    // An aborted core is already back in reset, so skip DRAIN.
                    if (aborted_r) begin
                        busy    <= 1'b0;
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_DRAIN;
                    end
`else
                    state_r <= ARB_DRAIN;
`endif
                end
                ARB_DRAIN: begin
                    if (!core_done) begin
                        busy    <= 1'b0;
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_DRAIN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt core model.
module tb_sqrt_arbiter;
    import sqrt_pkg::*;

    localparam int N_REQ    = 2;
    localparam int WIDTH    = 16;
    localparam int RW       = WIDTH / 2;
    localparam int DONE_DLY = 20;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_flat;
    logic [N_REQ-1:0]       ack;
    logic [RW-1:0]          res;
    logic                   err;
    logic                   busy;
    logic                   core_init;
    logic [WIDTH-1:0]       core_op;
    logic                   core_rst;
    logic                   core_done;
    logic [RW-1:0]          core_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef SQRT_ARB_TIMEOUT_EN
    sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT_CYC(8)) dut (
`else
    sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_flat   (op_flat),
        .ack       (ack),
        .res       (res),
        .err       (err),
        .busy      (busy),
        .core_init (core_init),
        .core_op   (core_op),
        .core_rst  (core_rst),
        .core_done (core_done),
        .core_res  (core_res)
    );

    // Core model: done DONE_DLY cycles after init, held DONE_HOLD_CYC cycles.
    logic [WIDTH-1:0] m_op;
    int               m_cnt;
    logic             m_active;
    logic             never_done;
    int               init_cnt = 0;
    int               crst_cnt = 0;
    int               ack1_cnt = 0;

    function automatic logic [RW-1:0] isqrt(input logic [WIDTH-1:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return RW'(r);
    endfunction

    always @(posedge clk) begin
        if (rst || core_rst) begin
            m_active  <= 1'b0;
            m_cnt     <= 0;
            core_done <= 1'b0;
            core_res  <= '0;
        end else if (core_init) begin
            m_active  <= 1'b1;
            m_cnt     <= 0;
            m_op      <= core_op;
            core_done <= 1'b0;
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == DONE_DLY - 1 && !never_done) begin
                core_done <= 1'b1;
                core_res  <= isqrt(m_op);
            end else if (m_cnt == DONE_DLY + DONE_HOLD_CYC - 1) begin
                core_done <= 1'b0;
                m_active  <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (core_init) init_cnt <= init_cnt + 1;
        if (core_rst)  crst_cnt <= crst_cnt + 1;
        if (ack[1])    ack1_cnt <= ack1_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_any_ack(input string tag, output logic [N_REQ-1:0] a);
        a = '0;
        for (int k = 0; k < 300 && a == '0; k++) begin
            @(negedge clk);
            a = ack;
        end
        if (a == '0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy_low(input string tag);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic wait_init(input string tag);
        for (int k = 0; k < 20 && !core_init; k++) @(negedge clk);
        check_eq(tag, core_init, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 100 && !core_done; k++) @(negedge clk);
        check_eq(tag, core_done, 1'b1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [N_REQ-1:0] a;
        logic [N_REQ-1:0] e;
        int i0;
        int lat;

        rst = 1'b1; req = '0; op_flat = '0; never_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ack", ack, 2'b00);
        check_eq("rst_res", res, 8'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_init", core_init, 1'b0);
        check_eq("rst_op", core_op, 16'd0);
        check_eq("rst_crst", core_rst, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, op 144
        i0 = init_cnt;
        op_flat[15:0] = 16'd144;
        req = 2'b01;
        @(negedge clk);
        check_eq("single_init", core_init, 1'b1);
        check_eq("single_op", core_op, 16'd144);
        check_eq("single_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("single_init_pulse", core_init, 1'b0);
        wait_done("single_done");
        lat = 0;
        while (!ack[0] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("single_ack_lat", lat, 2);
        check_eq("single_ack", ack, 2'b01);
        check_eq("single_res", res, 8'd12);
        check_eq("single_err", err, 1'b0);
        req = 2'b00;
        @(negedge clk);
        check_eq("single_ack_1cyc", ack, 2'b00);
        wait_busy_low("single_busy_low");
        check_eq("single_done_low", core_done, 1'b0);
        check_eq("single_inits", init_cnt - i0, 1);

        // Contention from ptr=0
        pulse_rst();
        i0 = init_cnt;
        op_flat[15:0]  = 16'd81;
        op_flat[31:16] = 16'd65535;
        req = 2'b11;
        wait_any_ack("cont_a0", a);
        check_eq("cont_first", a, 2'b01);
        check_eq("cont_res0", res, 8'd9);
        req[0] = 1'b0;
        for (int k = 0; k < 30 && core_done; k++) @(negedge clk);
        check_eq("cont_no_reissue", init_cnt - i0, 1);
        wait_any_ack("cont_a1", a);
        check_eq("cont_second", a, 2'b10);
        check_eq("cont_res1", res, 8'd255);
        req[1] = 1'b0;
        check_eq("cont_inits", init_cnt - i0, 2);
        wait_busy_low("cont_busy_low");

        // Fairness: both held for 6 operations
        req = 2'b11;
        for (int n = 0; n < 6; n++) begin
            e = (n % 2 == 0) ? 2'b01 : 2'b10;
            wait_any_ack($sformatf("fair_wait%0d", n), a);
            check_eq($sformatf("fair_ack%0d", n), a, e);
            check_eq($sformatf("fair_res%0d", n), res, (n % 2 == 0) ? 8'd9 : 8'd255);
        end
        req = 2'b00;
        wait_busy_low("fair_busy_low");

        // Withdrawal of req[1] during WAIT
        i0 = ack1_cnt;
        op_flat[31:16] = 16'd100;
        req = 2'b10;
        wait_init("wd_init");
        op_flat[15:0] = 16'd49;
        req[0] = 1'b1;
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
        wait_done("wd_done");
        repeat (3) @(negedge clk);
        check_eq("wd_res_updated", res, 8'd10);
        check_eq("wd_no_ack1", ack1_cnt - i0, 0);
        wait_any_ack("wd_a0", a);
        check_eq("wd_next_ack", a, 2'b01);
        check_eq("wd_next_res", res, 8'd7);
        req = 2'b00;
        wait_busy_low("wd_busy_low");

        // Reset in the middle of WAIT
        op_flat[15:0] = 16'd144;
        req = 2'b01;
        wait_init("mrst_init");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", busy, 1'b0);
        check_eq("mrst_res", res, 8'd0);
        check_eq("mrst_op", core_op, 16'd0);
        check_eq("mrst_ack", ack, 2'b00);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op_flat[15:0] = 16'd49;
        req = 2'b01;
        wait_any_ack("mrst_a0", a);
        check_eq("mrst_after_ack", a, 2'b01);
        check_eq("mrst_after_res", res, 8'd7);
        req = 2'b00;
        wait_busy_low("mrst_busy_low");

`ifdef SQRT_ARB_TIMEOUT_EN
        // Timeout abort when the core never finishes
        never_done = 1'b1;
        i0 = crst_cnt;
        op_flat[15:0] = 16'd144;
        req = 2'b01;
        wait_any_ack("to_a0", a);
        check_eq("to_ack", a, 2'b01);
        check_eq("to_err", err, 1'b1);
        check_eq("to_res", res, 8'd0);
        check_eq("to_crst", crst_cnt - i0, 1);
        req = 2'b00;
        @(negedge clk);
        check_eq("to_busy", busy, 1'b0);
        never_done = 1'b0;
        req = 2'b01;
        wait_any_ack("to_next", a);
        check_eq("to_err_clear", err, 1'b0);
        check_eq("to_next_res", res, 8'd12);
        req = 2'b00;
        wait_busy_low("to_busy_low");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one sqrt_ASM core (control_sqrt plus its datapath) between N_REQ requesters, such as the CPU MMIO port and an accelerator port.
- Arbitrates round-robin and sequences the core's init/done protocol.
- Captures each result and returns it to the winning requester with a one-cycle ack.
- Sits between the peripheral bus decoders and the single sqrt core instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 16, operand width; result width is WIDTH/2.
- TIMEOUT_CYC, 255, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level; held high until ack
- op_flat  in  N_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]; stable while req[i] is high
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- res  out  WIDTH/2  result; valid in the ack cycle and held until the next ack
- err  out  1  high with ack when the operation aborted
- busy  out  1  high in every state except IDLE
- core_init  out  1  one-cycle start pulse to the core
- core_op  out  WIDTH  operand to the core
- core_rst  out  1  one-cycle abort reset to the core (OR'd with rst at the core)
- core_done  in  1  core done; stays high for about 10 cycles after completion
- core_res  in  WIDTH/2  core result

Behaviour:
- Reset (asynchronous): state=IDLE, ptr=0, ack=0, res=0, err=0, busy=0, core_init=0, core_op=0, core_rst=0, timer=0, owner=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any req bit is high, pick the first set bit searching from ptr upward with wrap.
  - Latch the winner into owner and latch its operand into core_op, then go to ISSUE.
  - core_op stays stable until the next grant.
- ISSUE: core_init=1 for exactly this cycle; go to WAIT.
- WAIT: on core_done=1, register core_res into res and go to RESP.
- RESP (one cycle): ack[owner]=1 if req[owner] is still high; otherwise the result is discarded and ack stays 0.
  - ptr = owner+1, modulo N_REQ.
  - Go to DRAIN.
- DRAIN: stay until core_done=0, then go to IDLE. This prevents reissuing while the core sits in END1.
- Arbitration latency: req rising in IDLE gives core_init 1 cycle later. ack follows the first core_done by 2 cycles.
- Simultaneous requests: the requester nearest at or above ptr wins. The winner's ack and a new req from another requester in the same cycle are fine; the new req is served after DRAIN.
- A req dropped mid-operation does not cancel the core operation; the ack is suppressed.
- A req that rises during ISSUE/WAIT/RESP/DRAIN waits for IDLE.
- core_done already high on entering WAIT from a stale run cannot occur, because DRAIN guarantees it is low.
- rst asserted mid-operation: everything returns to reset values immediately. The system rst also resets the core.

Optional Feature:
- Macro: SQRT_ARB_TIMEOUT_EN.
- With the macro:
  - timer is cleared in ISSUE and increments in WAIT.
  - When timer reaches TIMEOUT_CYC without core_done: core_rst=1 for one cycle, res=0, err=1, then go to RESP (ack rules unchanged).
  - DRAIN is then skipped and the block goes straight to IDLE.
  - err clears on the next ack.
- Without the macro: WAIT has no bound, core_rst and err are tied 0, and the timer is not synthesized.

Decomposition:
- Shared package sqrt_pkg holds:
  - state encoding constants ST_IDLE..ST_DRAIN (3-bit);
  - SQRT_WIDTH default;
  - DONE_HOLD_CYC=10, matching the core's END1 dwell.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. It takes req and ptr and returns a one-hot grant plus an index. It is reused by later shared peripherals.

Test Plan:
- Single request: req[0]=1, op=144; core model asserts done 20 cycles after init, holds it 10 cycles → core_init pulses once, ack[0]=1 with res=12, err=0, busy falls after done drops.
- Contention: req=2'b11, op0=81, op1=65535, ptr=0 → req0 served first (res=9), then req1 (res=255), ptr=0 afterwards, never two inits within the DRAIN window.
- Fairness: req[0] and req[1] continuously high for 6 operations → ack sequence alternates 0,1,0,1,0,1.
- Withdrawal: req[1] drops during WAIT → no ack[1], res still updated, next pending req[0] served.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs are 0 asynchronously and a subsequent req[0]=1, op=49 gives res=7.
- With SQRT_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: core never asserts done → core_rst pulse on cycle 8 of WAIT, ack[0]=1, err=1, res=0, busy=0 one cycle later.
